// File: rtl/seg7_to_bcd_reader.sv
// seg7_to_bcd_reader: debounces a 7-segment pattern and shifts each stable decoded digit into a two-digit BCD display.
module seg7_to_bcd_reader #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;
    localparam logic [3:0] LAST = 4'(STABLE_CYCLES - 1);
    state_t     state, state_d;
    logic [6:0] seg_q;
    logic [3:0] cnt, tens, ones, dig;
    logic       dv, err, ovf, legal;
    logic [6:0] seg;
    logic       blank, same, clr, load, commit;
    logic       unused_bits;
    assign unused_bits = ^{ui_in[7], uio_in[7:1]};
    assign seg    = ui_in[6:0];
    assign blank  = seg == 7'd0;
    assign same   = seg == seg_q;
    assign clr    = uio_in[0];
    assign load   = !blank && (state == IDLE || !same);
    assign commit = state == TRACK && same && cnt == LAST;
    always_comb begin
        dig   = 4'd0;
        legal = 1'b1;
        case (seg)
            7'b1111110: dig = 4'd0;
            7'b0110000: dig = 4'd1;
            7'b1101101: dig = 4'd2;
            7'b1111001: dig = 4'd3;
            7'b0110011: dig = 4'd4;
            7'b1011011: dig = 4'd5;
            7'b1011111: dig = 4'd6;
            7'b1110000: dig = 4'd7;
            7'b1111111: dig = 4'd8;
            7'b1111011: dig = 4'd9;
            default:    legal = 1'b0;
        endcase
    end
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = blank ? IDLE : TRACK;
            TRACK:   state_d = same ? (cnt == LAST ? HOLD : TRACK) : (blank ? IDLE : TRACK);
            default: state_d = same ? HOLD : (blank ? IDLE : TRACK);
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            seg_q <= '0;
            cnt   <= '0;
            tens  <= '0;
            ones  <= '0;
            dv    <= 1'b0;
            err   <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            // the pulse self-clears every edge, so it never outlives one cycle even if ena drops
            dv <= 1'b0;
            if (ena && clr) begin
                state <= IDLE;
                seg_q <= '0;
                cnt   <= '0;
                tens  <= '0;
                ones  <= '0;
                err   <= 1'b0;
                ovf   <= 1'b0;
            end else if (ena) begin
                state <= state_d;
                if (load) begin
                    seg_q <= seg;
                    cnt   <= '0;
                end else if (state == TRACK && same && cnt != LAST) begin
                    cnt <= cnt + 4'd1;
                end
                if (commit && legal) begin
                    tens <= ones;
                    ones <= dig;
                    dv   <= 1'b1;
                    if (tens != 4'd0) ovf <= 1'b1;
                end else if (commit) begin
                    err <= 1'b1;
                end
            end
        end
    end
    always_comb begin
        uo_out  = {tens, ones};
        uio_out = {4'b0000, ovf, state == TRACK, err, dv};
        uio_oe  = 8'b0000_1111;
    end
endmodule
